// File: rtl/router_sync_n.sv
// router_sync_n: channel synchroniser between the router FSM/register block
// and the NUM_PORTS output FIFOs. It latches the header destination, steers
// write enable and full status to that FIFO, and drives per-channel valid.
// It also pulses a per-channel soft reset when a destination leaves valid
// data unread for TIMEOUT consecutive cycles.
module router_sync_n #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  localparam int unsigned       CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_reg;
  logic                 addr_valid;
  logic                 addr_in_range;
  logic [NUM_PORTS-1:0] stall;
  logic [CNT_W-1:0]     cnt [NUM_PORTS];

  // Header address is in range when it names an existing channel.
  assign addr_in_range = ({1'b0, data_in} < PORT_LIMIT);

  // Destination latch; addr_err pulses for one cycle on an out-of-range header.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_reg   <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      addr_reg   <= data_in;
      addr_valid <= addr_in_range;
      addr_err   <= !addr_in_range;
    end else begin
      addr_err   <= 1'b0;
    end
  end

  // Steer write enable and full flag to the latched destination only.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_valid && (addr_reg == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  // Valid-out mirrors FIFO occupancy, independent of reset.
  assign vld_out = ~empty;

  // A channel stalls while it has data but its destination is not reading.
  assign stall = vld_out & ~read_enb;

  // Per-channel stall counters; reaching TIMEOUT-1 while still stalled emits
  // a single soft-reset pulse and restarts the count.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!resetn || !stall[i]) begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b1;
      end else begin
        cnt[i]        <= cnt[i] + CNT_W'(1);
        soft_reset[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Testbench for router_sync_n: directed scenarios plus a randomized run
// checked against a behavioural model that tracks stall run lengths.
module tb_router_sync_n;

  localparam int NP = 3;
  localparam int AW = 2;
  localparam int TO = 30;

  logic          clock = 1'b0;
  logic          resetn;
  logic          detect_add;
  logic [AW-1:0] data_in;
  logic          write_enb_reg;
  logic [NP-1:0] read_enb;
  logic [NP-1:0] empty;
  logic [NP-1:0] full;
  logic [NP-1:0] write_enb;
  logic          fifo_full;
  logic [NP-1:0] vld_out;
  logic [NP-1:0] soft_reset;
  logic          addr_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int      m_addr = 0;
  bit      m_valid = 0;
  bit      m_err = 0;
  int      m_run [NP];
  logic [NP-1:0] m_sr = '0;

  router_sync_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // One rising edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clock);
    if (!resetn) begin
      m_addr = 0; m_valid = 0; m_err = 0; m_sr = '0;
      for (int i = 0; i < NP; i++) m_run[i] = 0;
    end else begin
      if (detect_add) begin
        m_addr  = int'(data_in);
        m_valid = (m_addr < NP);
        m_err   = !m_valid;
      end else begin
        m_err = 0;
      end
      for (int i = 0; i < NP; i++) begin
        if (!empty[i] && !read_enb[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        m_sr[i] = (m_run[i] > 0) && (m_run[i] % TO == 0);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    detect_add = 0; data_in = '0; write_enb_reg = 0;
    read_enb = '0; empty = '1; full = '0;
  endtask

  task automatic test_reset();
    resetn = 0; idle_inputs(); empty = 3'b010;
    tick();
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL reset_write_enb: got %b expected 000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    checks++; if (soft_reset !== 3'b000) begin failures++; $display("FAIL reset_soft_reset: got %b expected 000", soft_reset); end
    checks++; if (vld_out !== 3'b101) begin failures++; $display("FAIL reset_vld_out: got %b expected 101", vld_out); end
    resetn = 1; empty = '1;
    tick();
  endtask

  task automatic test_addr_latch();
    detect_add = 1; data_in = 2'd2; write_enb_reg = 1; full = 3'b100;
    #1;
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL latch_before_edge: got %b expected 000", write_enb); end
    tick();
    detect_add = 0;
    #1;
    checks++; if (write_enb !== 3'b100) begin failures++; $display("FAIL latch_write_enb: got %b expected 100", write_enb); end
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL latch_full_set: got %b expected 1", fifo_full); end
    full = 3'b011; #1;
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL latch_full_clear: got %b expected 0", fifo_full); end
    write_enb_reg = 0; #1;
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL latch_we_off: got %b expected 000", write_enb); end
    tick();
  endtask

  task automatic test_fifo_full();
    full = 3'b010; detect_add = 1; data_in = 2'd1;
    tick();
    detect_add = 0; #1;
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL full_addr1: got %b expected 1", fifo_full); end
    // write in the same cycle as a new header steers to the old address
    detect_add = 1; data_in = 2'd0; write_enb_reg = 1; #1;
    checks++; if (write_enb !== 3'b010) begin failures++; $display("FAIL full_same_cycle_we: got %b expected 010", write_enb); end
    tick();
    detect_add = 0; #1;
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL full_addr0: got %b expected 0", fifo_full); end
    checks++; if (write_enb !== 3'b001) begin failures++; $display("FAIL full_addr0_we: got %b expected 001", write_enb); end
    write_enb_reg = 0; full = '0;
    tick();
  endtask

  task automatic test_timeout();
    empty = 3'b110; read_enb = '0;
    for (int e = 1; e <= 2 * TO; e++) begin
      logic [NP-1:0] exp_sr;
      tick();
      exp_sr = (e == TO || e == 2 * TO) ? 3'b001 : 3'b000;
      checks++;
      if (soft_reset !== exp_sr) begin
        failures++; $display("FAIL timeout_edge%0d: got %b expected %b", e, soft_reset, exp_sr);
      end
    end
    empty = '1;
    tick();
    checks++; if (soft_reset !== 3'b000) begin failures++; $display("FAIL timeout_release: got %b expected 000", soft_reset); end
  endtask

  task automatic test_read_clears();
    empty = 3'b101; read_enb = '0;
    for (int e = 1; e <= TO; e++) begin
      read_enb = (e == TO) ? 3'b010 : 3'b000;
      tick();
      checks++;
      if (soft_reset !== 3'b000) begin failures++; $display("FAIL read_clear_edge%0d: got %b expected 000", e, soft_reset); end
    end
    read_enb = '0;
    for (int e = 1; e <= TO + 1; e++) begin
      logic [NP-1:0] exp_sr;
      tick();
      exp_sr = (e == TO) ? 3'b010 : 3'b000;
      checks++;
      if (soft_reset !== exp_sr) begin failures++; $display("FAIL restall_edge%0d: got %b expected %b", e, soft_reset, exp_sr); end
    end
    empty = '1;
    tick();
  endtask

  task automatic test_invalid_addr();
    detect_add = 1; data_in = 2'd3; full = '1;
    tick();
    detect_add = 0; write_enb_reg = 1; #1;
    checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL inv_addr_err: got %b expected 1", addr_err); end
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL inv_write_enb: got %b expected 000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL inv_fifo_full: got %b expected 0", fifo_full); end
    tick();
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL inv_err_one_cycle: got %b expected 0", addr_err); end
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL inv_we_hold: got %b expected 000", write_enb); end
    write_enb_reg = 0; full = '0;
  endtask

  task automatic test_reset_mid_stall();
    detect_add = 1; data_in = 2'd2;
    tick();
    detect_add = 0; write_enb_reg = 1; empty = 3'b110; read_enb = '0;
    for (int e = 1; e < 20; e++) tick();
    checks++; if (write_enb !== 3'b100) begin failures++; $display("FAIL rst_mid_pre_we: got %b expected 100", write_enb); end
    resetn = 0;
    tick();
    checks++; if (write_enb !== 3'b000) begin failures++; $display("FAIL rst_mid_we: got %b expected 000", write_enb); end
    checks++; if (soft_reset !== 3'b000) begin failures++; $display("FAIL rst_mid_sr: got %b expected 000", soft_reset); end
    resetn = 1;
    for (int e = 1; e <= TO + 1; e++) begin
      logic [NP-1:0] exp_sr;
      tick();
      exp_sr = (e == TO) ? 3'b001 : 3'b000;
      checks++;
      if (soft_reset !== exp_sr) begin failures++; $display("FAIL rst_mid_edge%0d: got %b expected %b", e, soft_reset, exp_sr); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    resetn = 0; idle_inputs();
    tick();
    resetn = 1;
    for (int n = 0; n < 3000; n++) begin
      logic [NP-1:0] exp_we;
      logic          exp_ff;
      resetn        = ($urandom_range(0, 499) != 0);
      detect_add    = ($urandom_range(0, 3) == 0);
      data_in       = AW'($urandom_range(0, 3));
      write_enb_reg = 1'($urandom_range(0, 1));
      full          = NP'($urandom);
      for (int i = 0; i < NP; i++) begin
        read_enb[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) empty[i] = ~empty[i];
      end
      tick();
      exp_we = '0;
      if (m_valid && write_enb_reg) exp_we[m_addr] = 1'b1;
      exp_ff = m_valid ? full[m_addr] : 1'b0;
      checks++; if (write_enb !== exp_we) begin failures++; $display("FAIL rnd_write_enb cyc%0d: got %b expected %b", n, write_enb, exp_we); end
      checks++; if (fifo_full !== exp_ff) begin failures++; $display("FAIL rnd_fifo_full cyc%0d: got %b expected %b", n, fifo_full, exp_ff); end
      checks++; if (vld_out !== ~empty) begin failures++; $display("FAIL rnd_vld_out cyc%0d: got %b expected %b", n, vld_out, ~empty); end
      checks++; if (soft_reset !== m_sr) begin failures++; $display("FAIL rnd_soft_reset cyc%0d: got %b expected %b", n, soft_reset, m_sr); end
      checks++; if (addr_err !== m_err) begin failures++; $display("FAIL rnd_addr_err cyc%0d: got %b expected %b", n, addr_err, m_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) m_run[i] = 0;
    resetn = 0; idle_inputs();
    @(negedge clock);
    test_reset();
    test_addr_latch();
    test_fifo_full();
    test_timeout();
    test_read_clears();
    test_invalid_addr();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
